// File: rtl/multicycle_ctrl_unit.sv
// Multicycle MIPS control FSM: decodes Op/Funct and drives datapath strobes. Optional feature: CTRL_ILLEGAL_TRAP_EN.
// Latency: 3-5 cycles per instruction at zero wait. Backpressure: Mem_Req states hold on Mem_Ready, abort after MEM_TIMEOUT waits.
module multicycle_ctrl_unit #(
    parameter int ALU_CTRL_W  = 3,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            Op,
    input  logic [5:0]            Funct,
    input  logic                  Mem_Ready,
    output logic                  Mem_Req,
    output logic                  IorD,
    output logic                  Mem_Write,
    output logic                  IR_Write,
    output logic                  PC_Write,
    output logic                  Reg_Write,
    output logic                  PC_Src,
    output logic                  Branch,
    output logic                  Branch_Ne,
    output logic                  ALU_SrcA,
    output logic                  Mem_Reg,
    output logic                  PC_J,
    output logic [ALU_CTRL_W-1:0] ALU_Control,
    output logic [1:0]            ALU_SrcB,
    output logic [1:0]            Reg_Dst,
    output logic [1:0]            Zero_Ext,
    output logic                  Mem_Err,
    output logic                  Illegal,
    output logic [CNT_W-1:0]      Instr_Count,
    output logic [3:0]            State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC     = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_WB       = 4'd4,
        S_BRANCH   = 4'd5,
        S_JUMP     = 4'd6,
        S_JAL_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_MEM_RD   = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d, OP_LUI  = 6'h0f, OP_MUL  = 6'h1c;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2b;
    localparam logic [5:0] F_JR  = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24, F_OR  = 6'h25, F_SLT = 6'h2a;
    localparam logic [TO_W-1:0] TO_LAST = (MEM_TIMEOUT == 0) ? '0 : TO_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_count;
    logic              w_retire;
    logic              w_mem_st;
    logic              w_timeout;
    logic              w_r_legal;
    logic              w_imm;
    logic              w_legal;
    logic              w_jr;
    logic [2:0]        w_alu;
    logic [2:0]        w_exec_alu;
    logic [1:0]        w_exec_srcb;
    logic [1:0]        w_exec_regdst;
    logic [1:0]        w_exec_zext;

    assign w_r_legal = (Funct == F_ADD) || (Funct == F_SUB) || (Funct == F_AND) ||
                       (Funct == F_OR)  || (Funct == F_SLT) || (Funct == F_JR);
    assign w_imm     = (Op == OP_ADDI) || (Op == OP_ADDIU) || (Op == OP_SLTI) ||
                       (Op == OP_ANDI) || (Op == OP_ORI)   || (Op == OP_LUI);
    assign w_legal   = ((Op == OP_RTYPE) && w_r_legal) || (Op == OP_MUL) || w_imm ||
                       (Op == OP_BEQ) || (Op == OP_BNE) || (Op == OP_J) || (Op == OP_JAL) ||
                       (Op == OP_LW)  || (Op == OP_SW);
    assign w_jr      = (Op == OP_RTYPE) && (Funct == F_JR);

    assign w_mem_st  = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    // The cycle whose wait would make the count reach MEM_TIMEOUT is the abort cycle.
    assign w_timeout = (MEM_TIMEOUT != 0) && w_mem_st && !Mem_Ready && (r_to_cnt == TO_LAST);

    always_comb begin
        w_exec_alu    = 3'b001;
        w_exec_srcb   = 2'b00;
        w_exec_regdst = 2'b01;
        w_exec_zext   = 2'b00;
        if (Op == OP_RTYPE) begin
            case (Funct)
                F_SUB:   w_exec_alu = 3'b100;
                F_AND:   w_exec_alu = 3'b010;
                F_OR:    w_exec_alu = 3'b011;
                F_SLT:   w_exec_alu = 3'b101;
                F_JR:    w_exec_alu = 3'b111;
                default: w_exec_alu = 3'b001;
            endcase
        end else if (Op == OP_MUL) begin
            w_exec_alu = 3'b110;
        end else begin
            w_exec_srcb   = 2'b10;
            w_exec_regdst = 2'b00;
            case (Op)
                OP_ADDIU: w_exec_zext = 2'b11;
                OP_SLTI:  w_exec_alu  = 3'b101;
                OP_ANDI:  begin w_exec_alu = 3'b010; w_exec_zext = 2'b01; end
                OP_ORI:   begin w_exec_alu = 3'b011; w_exec_zext = 2'b01; end
                OP_LUI:   w_exec_zext = 2'b10;
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:    if (Mem_Ready) w_next = S_DECODE;
                        else if (w_timeout) w_next = S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J:           w_next = S_JUMP;
                    OP_JAL:         w_next = S_JAL_WB;
                    OP_LW, OP_SW:   w_next = S_MEM_ADDR;
                    default: begin
                        if (w_legal) begin
                            w_next = S_EXEC;
                        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                            w_next = S_TRAP;
`else
                            w_next   = S_FETCH;
                            w_retire = 1'b1;
`endif
                        end
                    end
                endcase
            end
            S_EXEC: begin
                if (w_jr) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM_ADDR: w_next = (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_WB, S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_JAL_WB:   w_next = S_JUMP;
            S_MEM_RD:   if (Mem_Ready) w_next = S_WB;
                        else if (w_timeout) w_next = S_FETCH;
            S_MEM_WR: begin
                if (Mem_Ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next = S_FETCH;
                end
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     w_next = S_TRAP;
`else
            S_TRAP:     w_next = S_FETCH;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_to_cnt  <= '0;
            r_mem_err <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || w_timeout) r_to_cnt <= '0;
            else if (w_mem_st && !Mem_Ready)    r_to_cnt <= r_to_cnt + 1'b1;
            if (w_timeout) r_mem_err <= 1'b1;
            if (w_retire)  r_count   <= r_count + 1'b1;
        end
    end

    always_comb begin
        Mem_Req   = 1'b0;
        IorD      = 1'b0;
        Mem_Write = 1'b0;
        IR_Write  = 1'b0;
        PC_Write  = 1'b0;
        Reg_Write = 1'b0;
        PC_Src    = 1'b0;
        Branch    = 1'b0;
        Branch_Ne = 1'b0;
        ALU_SrcA  = 1'b0;
        Mem_Reg   = 1'b0;
        PC_J      = 1'b0;
        w_alu     = 3'b000;
        ALU_SrcB  = 2'b00;
        Reg_Dst   = 2'b00;
        Zero_Ext  = 2'b00;
        case (r_state)
            S_FETCH: begin
                Mem_Req  = 1'b1;
                w_alu    = 3'b001;
                ALU_SrcB = 2'b01;
                PC_J     = 1'b1;
                IR_Write = Mem_Ready;
                PC_Write = Mem_Ready;
            end
            S_DECODE: begin
                w_alu    = 3'b001;
                ALU_SrcB = 2'b11;
            end
            S_EXEC, S_WB: begin
                if ((r_state == S_WB) && (Op == OP_LW)) begin
                    Reg_Write = 1'b1;
                    Mem_Reg   = 1'b1;
                end else begin
                    ALU_SrcA = 1'b1;
                    w_alu    = w_exec_alu;
                    ALU_SrcB = w_exec_srcb;
                    Reg_Dst  = w_exec_regdst;
                    Zero_Ext = w_exec_zext;
                    if (r_state == S_WB) begin
                        Reg_Write = 1'b1;
                    end else if (w_jr) begin
                        PC_Write = 1'b1;
                        PC_Src   = 1'b1;
                    end
                end
            end
            S_MEM_ADDR: begin
                IorD     = 1'b1;
                ALU_SrcA = 1'b1;
                ALU_SrcB = 2'b10;
                w_alu    = 3'b001;
            end
            S_BRANCH: begin
                ALU_SrcA  = 1'b1;
                w_alu     = 3'b100;
                PC_Src    = 1'b1;
                Branch    = (Op == OP_BEQ);
                Branch_Ne = (Op == OP_BNE);
            end
            S_JUMP: begin
                PC_Write = 1'b1;
                PC_Src   = 1'b1;
            end
            S_JAL_WB: begin
                Reg_Write = 1'b1;
                Reg_Dst   = 2'b10;
                w_alu     = 3'b111;
            end
            S_MEM_RD: begin
                Mem_Req = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WR: begin
                Mem_Req   = 1'b1;
                IorD      = 1'b1;
                Mem_Write = 1'b1;
            end
            default: ;
        endcase
    end

    assign ALU_Control = ALU_CTRL_W'(w_alu);
    assign Mem_Err     = r_mem_err;
    assign Instr_Count = r_count;
    assign State       = r_state;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign Illegal     = (r_state == S_TRAP);
`else
    assign Illegal     = 1'b0;
`endif

endmodule
